// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Channel-wise partial-sum accumulator feeding the hard-swish activation
// segment. A burst of signed MAC products (first .. last) is summed onto a
// per-channel bias. The final sum is saturated to DATA_WIDTH and presented
// with a one-cycle valid strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides en)
//   en         global stall; when 0 every register holds
//   in_valid   product beat present
//   in_data    signed product (PROD_WIDTH)
//   first      beat is the first term of a burst
//   last       beat is the final term of a burst
//   bias       signed bias (DATA_WIDTH), sampled on a first beat
//   out_data   signed saturated burst result (DATA_WIDTH)
//   out_valid  one-cycle result strobe
//   out_sat    result was clipped (qualifies out_valid)
//   busy       burst in progress
//   err        sticky protocol-error flag, cleared only by rst
// ---------------------------------------------------------------------------
module psum_accumulator #(
  parameter int DATA_WIDTH = 26,
  parameter int PROD_WIDTH = 16,
  parameter int FRAC_BITS  = 9,
  parameter int GUARD_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  first,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sat,
  output logic                  busy,
  output logic                  err
);

  localparam int ACC_W = DATA_WIDTH + GUARD_BITS;

  // Products and bias share the same binary point, so the fractional width
  // only matters as a sanity bound on the parameter set.
  if (GUARD_BITS < 1 || PROD_WIDTH > DATA_WIDTH || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
    $error("psum_accumulator: inconsistent width parameters");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ACC_W-1:0]        acc_reg, acc_next;
  logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    out_sat_reg, out_sat_next;
  logic                    err_reg, err_next;

  // Datapath signals
  logic                    start_burst;
  logic                    proto_err;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W-1:0]        bias_ext;
  logic [ACC_W-1:0]        base;
  logic [ACC_W:0]          sum_wide;
  logic [ACC_W-1:0]        sum;
  logic                    sum_in_range;
  logic [DATA_WIDTH-1:0]   sum_sat;

  localparam logic [ACC_W-1:0]      ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]      ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_comb begin
    prod_ext = {{(ACC_W-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
    bias_ext = {{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};

    // A beat arriving while idle always opens a burst, with or without
    // first; a first beat mid-burst throws the running sum away.
    start_burst = (state_reg == IDLE) || first;
    proto_err   = ((state_reg == IDLE) && !first) || ((state_reg == ACC) && first);

    base     = start_burst ? bias_ext : acc_reg;
    sum_wide = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};

    // The guard bits make overflow of the accumulator practically
    // unreachable; should it happen anyway, clamp rather than wrap so the
    // sign of the result can never flip.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = sum_wide[ACC_W-1:0];
    end

    // Result fits DATA_WIDTH when all bits from the DATA_WIDTH sign bit
    // upward agree.
    sum_in_range = (sum[ACC_W-1:DATA_WIDTH-1] == '0) ||
                   (sum[ACC_W-1:DATA_WIDTH-1] == '1);

    if (sum_in_range) begin
      sum_sat = sum[DATA_WIDTH-1:0];
    end else if (sum[ACC_W-1]) begin
      sum_sat = DATA_MIN;
    end else begin
      sum_sat = DATA_MAX;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    out_sat_next   = out_sat_reg;
    err_next       = err_reg;

    if (in_valid) begin
      acc_next = sum;
      if (proto_err) begin
        err_next = 1'b1;
      end
      if (last) begin
        state_next     = IDLE;
        out_valid_next = 1'b1;
        out_data_next  = sum_sat;
        out_sat_next   = !sum_in_range;
      end else begin
        state_next = ACC;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers: everything freezes while en is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sat_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else if (en) begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_sat_reg   <= out_sat_next;
      err_reg       <= err_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sat   = out_sat_reg;
  assign busy      = (state_reg == ACC);
  assign err       = err_reg;

endmodule
